// File: rtl/exec_cc_stage.sv
// Y86-64 execute back end: condition-code register, jXX/cmovXX condition
// evaluation and the E->M pipeline register with stall/bubble.
module exec_cc_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] alu_result,
  input  logic         alu_ovf,
  input  logic [3:0]   dstE,
  input  logic         cc_block,
  input  logic         stall,
  input  logic         bubble,
  output logic         cnd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         m_valid,
  output logic [W-1:0] m_valE,
  output logic         m_cnd,
  output logic [3:0]   m_dstE
);
  localparam logic [3:0] I_RRMOV = 4'd2;
  localparam logic [3:0] I_OPQ   = 4'd6;
  localparam logic [3:0] I_JXX   = 4'd7;
  localparam logic [3:0] R_NONE  = 4'hF;

  logic         r_zf, r_sf, r_of;
  logic         r_m_valid, r_m_cnd;
  logic [W-1:0] r_m_valE;
  logic [3:0]   r_m_dstE;
  logic         w_cond, w_lt, w_set_cc;
  logic [3:0]   w_dstE;

  // Conditions read the stored flags only; an OPq in this cycle is not bypassed.
  always_comb begin
    w_lt   = r_sf ^ r_of;
    w_cond = 1'b0;
    case (ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = w_lt | r_zf;
      4'd2:    w_cond = w_lt;
      4'd3:    w_cond = r_zf;
      4'd4:    w_cond = ~r_zf;
      4'd5:    w_cond = ~w_lt;
      4'd6:    w_cond = ~w_lt & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign cnd      = ((icode == I_RRMOV) || (icode == I_JXX)) ? w_cond : 1'b0;
  assign w_set_cc = in_valid & (icode == I_OPQ) & ~cc_block & ~stall & ~bubble;
  // A not-taken cmov, or an invalid slot, must not write the register file.
  assign w_dstE   = (!in_valid || ((icode == I_RRMOV) && !cnd)) ? R_NONE : dstE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zf      <= 1'b1;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_valE  <= '0;
      r_m_cnd   <= 1'b0;
      r_m_dstE  <= R_NONE;
    end else begin
      if (w_set_cc) begin
        r_zf <= (alu_result == '0);
        r_sf <= alu_result[W-1];
        r_of <= alu_ovf;
      end
      if (!stall) begin
        if (bubble) begin
          r_m_valid <= 1'b0;
          r_m_valE  <= '0;
          r_m_cnd   <= 1'b0;
          r_m_dstE  <= R_NONE;
        end else begin
          r_m_valid <= in_valid;
          r_m_valE  <= alu_result;
          r_m_cnd   <= cnd;
          r_m_dstE  <= w_dstE;
        end
      end
    end
  end

  assign cc_zf   = r_zf;
  assign cc_sf   = r_sf;
  assign cc_of   = r_of;
  assign m_valid = r_m_valid;
  assign m_valE  = r_m_valE;
  assign m_cnd   = r_m_cnd;
  assign m_dstE  = r_m_dstE;
endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed vector table for exec_cc_stage plus a condition sweep against a flag model.
module tb_exec_cc_stage;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, in_valid, alu_ovf, cc_block, stall, bubble;
  logic [3:0]   icode, ifun, dstE;
  logic [W-1:0] alu_result;
  logic         cnd, cc_zf, cc_sf, cc_of, m_valid, m_cnd;
  logic [W-1:0] m_valE;
  logic [3:0]   m_dstE;

  int n_chk = 0;
  int n_fail = 0;

  exec_cc_stage #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .dstE(dstE), .cc_block(cc_block),
    .stall(stall), .bubble(bubble), .cnd(cnd), .cc_zf(cc_zf), .cc_sf(cc_sf),
    .cc_of(cc_of), .m_valid(m_valid), .m_valE(m_valE), .m_cnd(m_cnd), .m_dstE(m_dstE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, vld, ovf, blk, stl, bub;
    logic [3:0]   ic, fn, dst;
    logic [W-1:0] res;
    logic         e_cnd, e_zf, e_sf, e_of, e_mv, e_mc;
    logic [W-1:0] e_valE;
    logic [3:0]   e_mdst;
  } vec_t;

  vec_t tbl[$];

  // Control bits packed as {rst,vld,blk,stl,bub}; expected flags as {zf,sf,of}.
  function automatic vec_t mk(input logic [4:0] ctl, input logic [3:0] ic, fn, dst,
                              input logic [W-1:0] res, input logic ovf, input logic e_cnd,
                              input logic [2:0] e_f, input logic e_mv, input logic [W-1:0] e_valE,
                              input logic e_mc, input logic [3:0] e_mdst);
    vec_t v;
    {v.rst, v.vld, v.blk, v.stl, v.bub} = ctl;
    v.ic = ic; v.fn = fn; v.dst = dst; v.res = res; v.ovf = ovf;
    v.e_cnd = e_cnd; {v.e_zf, v.e_sf, v.e_of} = e_f;
    v.e_mv = e_mv; v.e_valE = e_valE; v.e_mc = e_mc; v.e_mdst = e_mdst;
    return v;
  endfunction

  function automatic logic model_cond(input logic [3:0] fn, input logic zf, sf, of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; in_valid = v.vld; cc_block = v.blk; stall = v.stl; bubble = v.bub;
    icode = v.ic; ifun = v.fn; dstE = v.dst; alu_result = v.res; alu_ovf = v.ovf;
  endtask

  localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] M2  = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    vec_t v;
    logic zf, sf, of;
    reset = 1'b1; in_valid = 1'b0; cc_block = 1'b0; stall = 1'b0; bubble = 1'b0;
    icode = 4'd7; ifun = 4'd3; dstE = 4'hF; alu_result = '0; alu_ovf = 1'b0;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst zf", cc_zf, 1); chk("rst sf", cc_sf, 0); chk("rst of", cc_of, 0);
    chk("rst mv", m_valid, 0); chk("rst valE", m_valE, 0); chk("rst mcnd", m_cnd, 0);
    chk("rst mdst", m_dstE, 4'hF); chk("rst je cnd", cnd, 1);

    //            {rst,vld,blk,stl,bub} ic  fn  dst  res      ovf cnd flags   mv valE     mc mdst
    tbl.push_back(mk(5'b01000, 7, 3, 15, 64'h11,   0, 1, 3'b100, 1, 64'h11,   1, 15));
    tbl.push_back(mk(5'b01000, 6, 1,  2, MIN,      1, 0, 3'b011, 1, MIN,      0,  2));
    tbl.push_back(mk(5'b01000, 7, 2, 15, 64'h0,    0, 0, 3'b011, 1, 64'h0,    0, 15));
    tbl.push_back(mk(5'b01000, 7, 1, 15, 64'h0,    0, 0, 3'b011, 1, 64'h0,    0, 15));
    tbl.push_back(mk(5'b01000, 7, 5, 15, 64'h0,    0, 1, 3'b011, 1, 64'h0,    1, 15));
    tbl.push_back(mk(5'b01000, 7, 6, 15, 64'h0,    0, 1, 3'b011, 1, 64'h0,    1, 15));
    tbl.push_back(mk(5'b01000, 6, 0,  4, 64'h0,    0, 0, 3'b100, 1, 64'h0,    0,  4));
    tbl.push_back(mk(5'b01000, 2, 4,  3, 64'h1234, 0, 0, 3'b100, 1, 64'h1234, 0, 15));
    tbl.push_back(mk(5'b01000, 2, 3,  3, 64'h55,   0, 1, 3'b100, 1, 64'h55,   1,  3));
    tbl.push_back(mk(5'b01000, 2, 0,  5, 64'h7,    0, 1, 3'b100, 1, 64'h7,    1,  5));
    tbl.push_back(mk(5'b01011, 6, 0,  6, 64'h42,   0, 0, 3'b100, 1, 64'h7,    1,  5));
    tbl.push_back(mk(5'b01011, 6, 0,  6, 64'h42,   0, 0, 3'b100, 1, 64'h7,    1,  5));
    tbl.push_back(mk(5'b01000, 6, 0,  6, 64'h42,   0, 0, 3'b000, 1, 64'h42,   0,  6));
    tbl.push_back(mk(5'b01000, 6, 0,  1, 64'h0,    0, 0, 3'b100, 1, 64'h0,    0,  1));
    tbl.push_back(mk(5'b01100, 6, 0,  2, 64'h5,    0, 0, 3'b100, 1, 64'h5,    0,  2));
    tbl.push_back(mk(5'b01001, 7, 0, 15, 64'h9,    0, 1, 3'b100, 0, 64'h0,    0, 15));
    tbl.push_back(mk(5'b00000, 6, 0,  7, M1,       1, 0, 3'b100, 0, M1,       0, 15));
    tbl.push_back(mk(5'b00000, 2, 0,  3, 64'h3,    0, 1, 3'b100, 0, 64'h3,    1, 15));
    tbl.push_back(mk(5'b01010, 6, 0,  2, MIN,      1, 0, 3'b100, 0, 64'h3,    1, 15));
    tbl.push_back(mk(5'b11000, 6, 0,  2, MIN,      1, 0, 3'b100, 0, 64'h0,    0, 15));
    tbl.push_back(mk(5'b11011, 7, 0,  4, 64'h8,    0, 1, 3'b100, 0, 64'h0,    0, 15));
    tbl.push_back(mk(5'b01000, 6, 0,  1, M2,       0, 0, 3'b010, 1, M2,       0,  1));

    foreach (tbl[i]) begin
      v = tbl[i];
      @(negedge clk);
      drive(v);
      #1 chk($sformatf("v%0d cnd", i), cnd, v.e_cnd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d zf", i), cc_zf, v.e_zf);
      chk($sformatf("v%0d sf", i), cc_sf, v.e_sf);
      chk($sformatf("v%0d of", i), cc_of, v.e_of);
      chk($sformatf("v%0d mv", i), m_valid, v.e_mv);
      chk($sformatf("v%0d valE", i), m_valE, v.e_valE);
      chk($sformatf("v%0d mcnd", i), m_cnd, v.e_mc);
      chk($sformatf("v%0d mdst", i), m_dstE, v.e_mdst);
    end

    // Sweep ifun against the model under two flag states: (0,1,0) then (1,0,1).
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        @(negedge clk);
        drive(mk(5'b01000, 6, 0, 1, 64'h0, 1, 0, 3'b101, 1, 64'h0, 0, 1));
        @(posedge clk);
        #1 chk("sweep setup flags", {cc_zf, cc_sf, cc_of}, 3'b101);
      end
      zf = (pass == 1); sf = (pass == 0); of = (pass == 1);
      @(negedge clk);
      stall = 1'b1; in_valid = 1'b0;
      for (int f = 0; f < 16; f++) begin
        ifun = 4'(f);
        icode = 4'd7;
        #1 chk($sformatf("p%0d jxx ifun%0d", pass, f), cnd, model_cond(4'(f), zf, sf, of));
        icode = 4'd2;
        #1 chk($sformatf("p%0d cmov ifun%0d", pass, f), cnd, model_cond(4'(f), zf, sf, of));
        icode = 4'd3;
        #1 chk($sformatf("p%0d irmov ifun%0d", pass, f), cnd, 0);
      end
      stall = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
